sram_march_bist: RTL and testbench

- March C- built-in self-test engine that sits directly upstream of the 1024x32, byte-masked single-port SRAM macro.
- Drives the macro's `we`/`wmask`/`addr`/`din` pins and checks its `dout` against expected data.
- Reports pass/fail, first-failure location and a mismatch count to the BIST wrapper/scan registers.
- Runs one full March C- pass per `start` pulse.

---
 rtl/sram_march_bist.sv | 166 ++++++++++++++++
 tb/tb_sram_march_bist.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March C- BIST engine for a byte-masked single-port SRAM: issues one op per cycle
// and checks read data one cycle later. It records pass/fail, the first failure and a mismatch count.
module sram_march_bist #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  data_bg,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [2:0]             fail_element,
    output logic [CNT_WIDTH-1:0]   fail_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              elem;
    logic                    phase;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   bg_q;
    logic                    accept;
    logic                    is_down;
    logic                    op_last_in_addr;
    logic                    addr_at_end;
    logic                    last_op;
    logic                    is_read;
    logic                    is_write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [2:0]              rd_elem_q;
    logic                    mismatch;

    assign accept          = start && ((state == IDLE) || (state == DONE));
    assign is_down         = (elem == 3'd3) || (elem == 3'd4);
    assign op_last_in_addr = (elem == 3'd0) || (elem == 3'd5) || phase;
    assign addr_at_end     = is_down ? (addr_q == '0) : (addr_q == '1);
    assign last_op         = (elem == 3'd5) && addr_at_end;

    // Elements 0, 2 and 4 write the background; 1 and 3 write its inverse.
    assign wdata = ((elem == 3'd0) || (elem == 3'd2) || (elem == 3'd4)) ? bg_q : ~bg_q;
    assign rdata = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg_q : bg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_op) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_write   = 1'b0;
        is_read    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        busy       = (state == RUN) || (state == DRAIN);
        done       = (state == DONE);
        if (state == RUN) begin
            is_write  = (elem == 3'd0) || (phase && (elem != 3'd5));
            is_read   = !is_write;
            sram_addr = addr_q;
            if (is_write) begin
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_din   = wdata;
            end
        end
    end

    // Address/element sequencer: every op of an address finishes before the address steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem   <= 3'd0;
            phase  <= 1'b0;
            addr_q <= '0;
            bg_q   <= '0;
        end else if (accept) begin
            bg_q   <= data_bg;
            elem   <= 3'd0;
            phase  <= 1'b0;
            addr_q <= '0;
        end else if (state == RUN) begin
            if (!op_last_in_addr) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (addr_at_end) begin
                    if (elem != 3'd5) begin
                        elem   <= elem + 3'd1;
                        addr_q <= ((elem == 3'd2) || (elem == 3'd3)) ? '1 : '0;
                    end
                end else begin
                    addr_q <= is_down ? addr_q - 1'b1 : addr_q + 1'b1;
                end
            end
        end
    end

    assign mismatch = rd_valid && (sram_dout != exp_q);

    // A read's expectation is carried one cycle so it can be compared against sram_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid     <= 1'b0;
            exp_q        <= '0;
            rd_addr_q    <= '0;
            rd_elem_q    <= 3'd0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= 3'd0;
            fail_count   <= '0;
        end else begin
            rd_valid <= is_read;
            if (is_read) begin
                exp_q     <= rdata;
                rd_addr_q <= addr_q;
                rd_elem_q <= elem;
            end
            if (accept) begin
                fail         <= 1'b0;
                fail_addr    <= '0;
                fail_element <= 3'd0;
                fail_count   <= '0;
            end else if (mismatch) begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail) begin
                    fail         <= 1'b1;
                    fail_addr    <= rd_addr_q;
                    fail_element <= rd_elem_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: fault-free, stuck-at and coupling SRAM models,
// restart, mid-run reset and counter saturation on a small instance.
module tb_sram_march_bist;

    localparam int N      = 1024;
    localparam int OPS    = 10 * N;
    localparam int LIMIT  = OPS + 40;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_bg;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [9:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic        busy;
    logic        done;
    logic        fail;
    logic [9:0]  fail_addr;
    logic [2:0]  fail_element;
    logic [15:0] fail_count;

    logic        start_s;
    logic        sram_we_s;
    logic [3:0]  sram_wmask_s;
    logic [3:0]  sram_addr_s;
    logic [31:0] sram_din_s;
    logic [31:0] sram_dout_s;
    logic        busy_s;
    logic        done_s;
    logic        fail_s;
    logic [3:0]  fail_addr_s;
    logic [2:0]  fail_element_s;
    logic [3:0]  fail_count_s;

    logic [31:0] mem   [N];
    logic [31:0] mem_s [16];
    int          fault_mode;
    int          checks;
    int          failures;
    logic [46:0] trace [$];

    sram_march_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_bg(data_bg),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_element(fail_element),
        .fail_count(fail_count)
    );

    sram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WMASK_WIDTH(4), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data_bg(32'h0),
        .sram_we(sram_we_s), .sram_wmask(sram_wmask_s), .sram_addr(sram_addr_s),
        .sram_din(sram_din_s), .sram_dout(sram_dout_s), .busy(busy_s), .done(done_s),
        .fail(fail_s), .fail_addr(fail_addr_s), .fail_element(fail_element_s),
        .fail_count(fail_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault 1: bit 5 of 0x123 stuck at 0. Fault 2: any write to 0x010 flips bit 0 of 0x011.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end
            if (fault_mode == 2 && sram_addr == 10'h010) mem[10'h011][0] <= ~mem[10'h011][0];
            sram_dout <= 'x;
        end else if (fault_mode == 1 && sram_addr == 10'h123) begin
            sram_dout <= mem[sram_addr] & ~32'h20;
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    always @(posedge clk) begin
        if (sram_we_s) begin
            mem_s[sram_addr_s] <= sram_din_s;
            sram_dout_s <= 'x;
        end else begin
            sram_dout_s <= ~mem_s[sram_addr_s];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushOp(input bit we, input int a, input logic [31:0] d);
        logic [9:0] aa;
        aa = a[9:0];
        trace.push_back({we, we ? 4'hF : 4'h0, aa, we ? d : 32'h0});
    endtask

    task automatic applyStimulus(input logic [31:0] bg, input int fmode, input bit check_trace,
                                 input bit repulse, output int done_at, output int busy_cnt);
        int n;
        int trace_err;
        logic [46:0] pins;
        @(negedge clk);
        data_bg    = bg;
        fault_mode = fmode;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("clear_on_start", {done, fail, fail_addr, fail_element, fail_count}, 64'h0);
        checkOutput("busy_on_start", busy, 1);
        n         = 1;
        done_at   = -1;
        busy_cnt  = 0;
        trace_err = 0;
        while (n < LIMIT) begin
            if (done) begin
                done_at = n;
                break;
            end
            if (busy) busy_cnt++;
            if (check_trace) begin
                pins = {sram_we, sram_wmask, sram_addr, sram_din};
                if (n <= OPS) begin
                    if (pins !== trace[n-1]) trace_err++;
                end else if (pins !== 47'h0) begin
                    trace_err++;
                end
            end
            if (repulse && n == 500) begin
                start   = 1'b1;
                data_bg = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (check_trace) checkOutput("op_trace", trace_err, 0);
    endtask

    initial begin
        int done_at;
        int busy_cnt;
        int act;
        checks     = 0;
        failures   = 0;
        fault_mode = 0;
        start      = 1'b0;
        start_s    = 1'b0;
        data_bg    = 32'h0;
        rst_n      = 1'b0;

        for (int a = 0; a < N; a++) pushOp(1, a, 32'h0);
        for (int a = 0; a < N; a++) begin pushOp(0, a, 0); pushOp(1, a, 32'hFFFF_FFFF); end
        for (int a = 0; a < N; a++) begin pushOp(0, a, 0); pushOp(1, a, 32'h0); end
        for (int a = N-1; a >= 0; a--) begin pushOp(0, a, 0); pushOp(1, a, 32'hFFFF_FFFF); end
        for (int a = N-1; a >= 0; a--) begin pushOp(0, a, 0); pushOp(1, a, 32'h0); end
        for (int a = 0; a < N; a++) pushOp(0, a, 0);

        #1;
        checkOutput("reset_pins", {sram_we, sram_wmask, sram_addr, sram_din}, 64'h0);
        checkOutput("reset_status", {busy, done, fail, fail_addr, fail_element, fail_count}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fault-free pass with ignored re-start at cycle 500");
        applyStimulus(32'h0, 0, 1'b1, 1'b1, done_at, busy_cnt);
        checkOutput("ff_done_cycle", done_at, 10242);
        checkOutput("ff_busy_cycles", busy_cnt, 10241);
        checkOutput("ff_fail", fail, 0);
        checkOutput("ff_fail_count", fail_count, 0);
        checkOutput("ff_done_pins_idle", {sram_we, sram_wmask, sram_addr, sram_din}, 64'h0);

        $display("[TB] stuck-at-0 bit 5 of 0x123, background 0");
        applyStimulus(32'h0, 1, 1'b0, 1'b0, done_at, busy_cnt);
        checkOutput("sa0_done_cycle", done_at, 10242);
        checkOutput("sa0_fail", fail, 1);
        checkOutput("sa0_fail_element", fail_element, 2);
        checkOutput("sa0_fail_addr", fail_addr, 10'h123);
        checkOutput("sa0_fail_count", fail_count, 2);

        $display("[TB] stuck-at-0, background all ones, started from DONE");
        applyStimulus(32'hFFFF_FFFF, 1, 1'b0, 1'b0, done_at, busy_cnt);
        checkOutput("sa1_fail_element", fail_element, 1);
        checkOutput("sa1_fail_addr", fail_addr, 10'h123);
        checkOutput("sa1_fail_count", fail_count, 3);

        $display("[TB] coupling fault 0x010 -> 0x011 bit 0");
        applyStimulus(32'h0, 2, 1'b0, 1'b0, done_at, busy_cnt);
        checkOutput("cf_done_cycle", done_at, 10242);
        checkOutput("cf_fail", fail, 1);
        checkOutput("cf_fail_element", fail_element, 1);
        checkOutput("cf_fail_addr", fail_addr, 10'h011);
        checkOutput("cf_fail_count", fail_count, 4);

        $display("[TB] reset asserted mid-run");
        @(negedge clk);
        fault_mode = 1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2999) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_we", sram_we, 0);
        checkOutput("async_reset_pins", {sram_we, sram_wmask, sram_addr, sram_din}, 64'h0);
        checkOutput("async_reset_status", {busy, done, fail, fail_addr, fail_element, fail_count}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (sram_we || busy || done || sram_addr != 10'h0) act++;
        end
        checkOutput("idle_after_reset", act, 0);

        $display("[TB] saturation on 16-word instance with inverting memory");
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        done_at = -1;
        for (int n = 1; n < 200; n++) begin
            if (done_s) begin
                done_at = n;
                break;
            end
            @(negedge clk);
        end
        checkOutput("sat_done_cycle", done_at, 162);
        checkOutput("sat_fail", fail_s, 1);
        checkOutput("sat_fail_element", fail_element_s, 1);
        checkOutput("sat_fail_addr", fail_addr_s, 0);
        checkOutput("sat_fail_count", fail_count_s, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
